// File: rtl/combat_resolver_pkg.sv
// Shared game definitions: FSM state encoding, lane codes and default constants
// used by the combat resolver and the enemy datapath.
package combat_resolver_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_WARN     = 3'd1,
      ST_RESOLVE  = 3'd2,
      ST_COOLDOWN = 3'd3,
      ST_OVER     = 3'd4
   } state_e;

   localparam logic [1:0] LANE_LEFT   = 2'b00;
   localparam logic [1:0] LANE_CENTRE = 2'b01;
   localparam logic [1:0] LANE_RIGHT  = 2'b10;

   localparam int DEF_WARN_TICKS     = 3;
   localparam int DEF_COOLDOWN_TICKS = 2;
   localparam int DEF_PLAYER_HP      = 5;
   localparam int DEF_ENEMY_HP       = 7;

   localparam int CNT_W = 8;

   // The unused code 11 is folded onto the centre lane.
   function automatic logic [1:0] norm_lane(input logic [1:0] lane);
      return (lane == 2'b11) ? LANE_CENTRE : lane;
   endfunction

endpackage

// File: rtl/combat_resolver_tick_counter.sv
// Loadable down-counter advanced by the rate-divider tick; saturates at zero
// and flags it so the FSM can leave WARN/COOLDOWN.
module tick_counter #(
   parameter int W = 8
) (
   input  logic         clock,
   input  logic         resetn,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         tick_i,
   output logic         zero_o
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = load_val_i;
      end else if (tick_i && (count_q != '0)) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign zero_o = (count_q == '0);

endmodule

// File: rtl/combat_resolver.sv
// Combat resolver: warns of an enemy attack, resolves it against the player's
// lane and guard, tracks both health values and declares the winner.
//
// state       | meaning
// ------------+--------------------------------------------------------
// ST_IDLE     | waiting for an attack; punches accepted
// ST_WARN     | attack telegraphed, counting WARN_TICKS
// ST_RESOLVE  | single cycle: dodge / block / hit decided
// ST_COOLDOWN | counting COOLDOWN_TICKS; punches accepted, attacks dropped
// ST_OVER     | game finished, absorbing until reset
module combat_resolver
   import combat_resolver_pkg::*;
#(
   parameter int WARN_TICKS     = DEF_WARN_TICKS,
   parameter int COOLDOWN_TICKS = DEF_COOLDOWN_TICKS,
   parameter int PLAYER_HP      = DEF_PLAYER_HP,
   parameter int ENEMY_HP       = DEF_ENEMY_HP
) (
   input  logic       clock,
   input  logic       resetn,
   input  logic       tick,
   input  logic       attack_req,
   input  logic [1:0] enemy_lane,
   input  logic [1:0] player_lane,
   input  logic       block,
   input  logic       punch,
   output logic       warn,
   output logic       busy,
   output logic       hit_pulse,
   output logic       blocked_pulse,
   output logic       dodged_pulse,
   output logic       enemy_hit_pulse,
   output logic [2:0] player_hp,
   output logic [2:0] enemy_hp,
   output logic       game_over,
   output logic       winner
);

   localparam logic [CNT_W-1:0] WARN_LD = CNT_W'(WARN_TICKS);
   localparam logic [CNT_W-1:0] COOL_LD = CNT_W'(COOLDOWN_TICKS);
   localparam logic [2:0]       PHP_RST = 3'(PLAYER_HP);
   localparam logic [2:0]       EHP_RST = 3'(ENEMY_HP);

   state_e     state_q, state_d;
   logic [1:0] target_q, target_d;
   logic [2:0] php_q, php_d;
   logic [2:0] ehp_q, ehp_d;
   logic       winner_q, winner_d;
   logic       warn_q, busy_q, over_q;

   logic             cnt_load;
   logic [CNT_W-1:0] cnt_val;
   logic             cnt_zero;
   logic             punch_ok;
   logic             hit_c, blocked_c, dodged_c;

   tick_counter #(.W(CNT_W)) u_tick_counter (
      .clock      (clock),
      .resetn     (resetn),
      .load_i     (cnt_load),
      .load_val_i (cnt_val),
      .tick_i     (tick),
      .zero_o     (cnt_zero)
   );

   assign punch_ok = punch && !block &&
                     ((state_q == ST_IDLE) || (state_q == ST_COOLDOWN));

   always_comb begin
      state_d   = state_q;
      target_d  = target_q;
      php_d     = php_q;
      ehp_d     = ehp_q;
      winner_d  = winner_q;
      cnt_load  = 1'b0;
      cnt_val   = '0;
      hit_c     = 1'b0;
      blocked_c = 1'b0;
      dodged_c  = 1'b0;

      if (punch_ok && (ehp_q != 3'd0)) begin
         ehp_d = ehp_q - 3'd1;
      end

      case (state_q)
         ST_IDLE: begin
            // A knockout punch wins over an attack arriving in the same cycle.
            if (punch_ok && (ehp_d == 3'd0)) begin
               state_d  = ST_OVER;
               winner_d = 1'b1;
            end else if (attack_req) begin
               state_d  = ST_WARN;
               target_d = norm_lane(enemy_lane);
               cnt_load = 1'b1;
               cnt_val  = WARN_LD;
            end
         end
         ST_WARN: begin
            if (cnt_zero) begin
               state_d = ST_RESOLVE;
            end
         end
         ST_RESOLVE: begin
            if (norm_lane(player_lane) != target_q) begin
               dodged_c = 1'b1;
            end else if (block) begin
               blocked_c = 1'b1;
            end else begin
               hit_c = 1'b1;
               if (php_q != 3'd0) begin
                  php_d = php_q - 3'd1;
               end
            end
            if (php_d == 3'd0) begin
               state_d  = ST_OVER;
               winner_d = 1'b0;
            end else begin
               state_d  = ST_COOLDOWN;
               cnt_load = 1'b1;
               cnt_val  = COOL_LD;
            end
         end
         ST_COOLDOWN: begin
            if (punch_ok && (ehp_d == 3'd0)) begin
               state_d  = ST_OVER;
               winner_d = 1'b1;
            end else if (cnt_zero) begin
               state_d = ST_IDLE;
            end
         end
         ST_OVER: begin
            state_d = ST_OVER;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q  <= ST_IDLE;
         target_q <= LANE_CENTRE;
         php_q    <= PHP_RST;
         ehp_q    <= EHP_RST;
         winner_q <= 1'b0;
         warn_q   <= 1'b0;
         busy_q   <= 1'b0;
         over_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         target_q <= target_d;
         php_q    <= php_d;
         ehp_q    <= ehp_d;
         winner_q <= winner_d;
         warn_q   <= (state_d == ST_WARN);
         busy_q   <= (state_d != ST_IDLE);
         over_q   <= (state_d == ST_OVER);
      end
   end

   assign warn            = warn_q;
   assign busy            = busy_q;
   assign game_over       = over_q;
   assign winner          = winner_q;
   assign player_hp       = php_q;
   assign enemy_hp        = ehp_q;
   assign hit_pulse       = hit_c;
   assign blocked_pulse   = blocked_c;
   assign dodged_pulse    = dodged_c;
   assign enemy_hit_pulse = punch_ok;

endmodule

// File: tb/tb_combat_resolver.sv
// Directed bench for combat_resolver with default parameters; result pulses
// are tallied on the falling edge and compared against hand-derived counts.
module tb_combat_resolver;

   logic       clock = 1'b0;
   logic       resetn = 1'b0;
   logic       tick = 1'b0;
   logic       attack_req = 1'b0;
   logic [1:0] enemy_lane = 2'b00;
   logic [1:0] player_lane = 2'b00;
   logic       block = 1'b0;
   logic       punch = 1'b0;
   logic       warn, busy, hit_pulse, blocked_pulse, dodged_pulse, enemy_hit_pulse;
   logic [2:0] player_hp, enemy_hp;
   logic       game_over, winner;

   int n_chk = 0;
   int n_pass = 0;
   int n_hit = 0, n_blk = 0, n_dodge = 0, n_ehit = 0;
   int base_hit, base_ehit;

   combat_resolver dut (
      .clock           (clock),
      .resetn          (resetn),
      .tick            (tick),
      .attack_req      (attack_req),
      .enemy_lane      (enemy_lane),
      .player_lane     (player_lane),
      .block           (block),
      .punch           (punch),
      .warn            (warn),
      .busy            (busy),
      .hit_pulse       (hit_pulse),
      .blocked_pulse   (blocked_pulse),
      .dodged_pulse    (dodged_pulse),
      .enemy_hit_pulse (enemy_hit_pulse),
      .player_hp       (player_hp),
      .enemy_hp        (enemy_hp),
      .game_over       (game_over),
      .winner          (winner)
   );

   always #5 clock = ~clock;

   always @(negedge clock) begin
      if (hit_pulse)       n_hit++;
      if (blocked_pulse)   n_blk++;
      if (dodged_pulse)    n_dodge++;
      if (enemy_hit_pulse) n_ehit++;
   end

   task automatic check(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
   endtask

   task automatic clk1();
      @(posedge clock);
      #1;
   endtask

   task automatic tick1();
      tick = 1'b1;
      clk1();
      tick = 1'b0;
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      #2;
      resetn = 1'b1;
      clk1();
   endtask

   // Full attack: accept, 3 warn ticks, resolve, 2 cooldown ticks, back to idle.
   task automatic attack(input logic [1:0] el, input logic [1:0] pl, input logic bl);
      enemy_lane = el;
      player_lane = pl;
      block = bl;
      attack_req = 1'b1;
      clk1();
      attack_req = 1'b0;
      check("atk_warn_on", int'(warn), 1);
      repeat (3) tick1();
      check("atk_warn_cnt0", int'(warn), 1);
      clk1();
      check("atk_warn_off_resolve", int'(warn), 0);
      clk1();
      repeat (2) tick1();
      clk1();
      block = 1'b0;
   endtask

   initial begin
      repeat (2) clk1();
      resetn = 1'b1;
      clk1();
      check("rst_player_hp", int'(player_hp), 5);
      check("rst_enemy_hp", int'(enemy_hp), 7);
      check("rst_busy", int'(busy), 0);
      check("rst_game_over", int'(game_over), 0);
      check("rst_warn", int'(warn), 0);

      // hit on right lane
      attack(2'b10, 2'b10, 1'b0);
      check("hit_count", n_hit, 1);
      check("hit_player_hp", int'(player_hp), 4);
      check("hit_idle_busy", int'(busy), 0);

      attack(2'b10, 2'b00, 1'b0);
      check("dodge_count", n_dodge, 1);
      check("dodge_player_hp", int'(player_hp), 4);

      attack(2'b10, 2'b10, 1'b1);
      check("block_count", n_blk, 1);
      check("block_player_hp", int'(player_hp), 4);
      check("block_no_hit", n_hit, 1);

      // lane code 11 behaves as centre
      attack(2'b11, 2'b01, 1'b0);
      check("lane11_hit", n_hit, 2);
      check("lane11_player_hp", int'(player_hp), 3);

      // punch in WARN ignored, attack in COOLDOWN ignored
      enemy_lane = 2'b00; player_lane = 2'b00; attack_req = 1'b1;
      clk1();
      attack_req = 1'b0;
      punch = 1'b1;
      clk1();
      punch = 1'b0;
      check("warn_punch_enemy_hp", int'(enemy_hp), 7);
      check("warn_punch_pulse", n_ehit, 0);
      check("warn_punch_still_warn", int'(warn), 1);
      repeat (3) tick1();
      clk1();
      clk1();
      check("cool_player_hp", int'(player_hp), 2);
      attack_req = 1'b1;
      clk1();
      attack_req = 1'b0;
      repeat (2) tick1();
      clk1();
      clk1();
      check("cool_attack_dropped_busy", int'(busy), 0);
      check("cool_attack_dropped_warn", int'(warn), 0);
      check("cool_attack_hit_count", n_hit, 3);

      // guarded punch has no effect
      block = 1'b1; punch = 1'b1;
      clk1();
      block = 1'b0; punch = 1'b0;
      check("guard_punch_enemy_hp", int'(enemy_hp), 7);

      // simultaneous attack and punch in IDLE
      enemy_lane = 2'b00; player_lane = 2'b01;
      attack_req = 1'b1; punch = 1'b1;
      clk1();
      attack_req = 1'b0; punch = 1'b0;
      check("simul_enemy_hp", int'(enemy_hp), 6);
      check("simul_ehit", n_ehit, 1);
      check("simul_warn", int'(warn), 1);
      repeat (3) tick1();
      clk1();
      clk1();
      repeat (2) tick1();
      clk1();
      check("simul_dodge", n_dodge, 2);
      check("simul_busy", int'(busy), 0);

      // player loses
      do_reset();
      base_hit = n_hit;
      repeat (5) attack(2'b01, 2'b01, 1'b0);
      check("lose_hits", n_hit - base_hit, 5);
      check("lose_player_hp", int'(player_hp), 0);
      check("lose_game_over", int'(game_over), 1);
      check("lose_winner", int'(winner), 0);
      check("lose_busy", int'(busy), 1);

      // player wins with seven punches
      do_reset();
      base_ehit = n_ehit;
      for (int i = 0; i < 7; i++) begin
         punch = 1'b1;
         clk1();
         punch = 1'b0;
         clk1();
      end
      check("win_ehits", n_ehit - base_ehit, 7);
      check("win_enemy_hp", int'(enemy_hp), 0);
      check("win_game_over", int'(game_over), 1);
      check("win_winner", int'(winner), 1);
      base_hit = n_hit;
      enemy_lane = 2'b10; player_lane = 2'b10; attack_req = 1'b1;
      clk1();
      clk1();
      attack_req = 1'b0;
      repeat (4) tick1();
      check("over_attack_warn", int'(warn), 0);
      check("over_attack_hits", n_hit - base_hit, 0);
      check("over_still_over", int'(game_over), 1);
      check("over_player_hp", int'(player_hp), 5);

      // reset mid-WARN
      do_reset();
      attack(2'b10, 2'b10, 1'b0);
      punch = 1'b1;
      clk1();
      punch = 1'b0;
      check("pre_rst_player_hp", int'(player_hp), 4);
      check("pre_rst_enemy_hp", int'(enemy_hp), 6);
      base_hit = n_hit;
      enemy_lane = 2'b10; player_lane = 2'b10; attack_req = 1'b1;
      clk1();
      attack_req = 1'b0;
      tick1();
      check("mid_warn", int'(warn), 1);
      resetn = 1'b0;
      #1;
      check("async_rst_busy", int'(busy), 0);
      check("async_rst_warn", int'(warn), 0);
      check("async_rst_player_hp", int'(player_hp), 5);
      check("async_rst_enemy_hp", int'(enemy_hp), 7);
      resetn = 1'b1;
      repeat (6) tick1();
      check("abort_no_hit", n_hit - base_hit, 0);
      check("abort_busy", int'(busy), 0);
      check("abort_player_hp", int'(player_hp), 5);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
